ethmacfilt: RTL and testbench

- Destination-address filter for the Ethernet receive path.
- Consumes the 48-bit destination MAC and ready strobe produced by the receive-frame stage (mac_data/mac_rdy).
- Returns the cmp_done/cmp_res pair that the receiver waits on before it declares a frame received.
- Matches against the station address, broadcast, an all-multicast/promiscuous mode, and a loadable table of NADDR addresses (DELQA setup-frame style).

---
 rtl/ethmacfilt.sv | 187 ++++++++++++++++++
 tb/tb_ethmacfilt.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethmacfilt.sv
// Receive-path destination-address filter: station, broadcast, multicast and
// promiscuous checks, then a one-entry-per-cycle scan of a loadable address table.
module ethmacfilt #(
    parameter int NADDR = 14,
    parameter int IDXW  = 4
) (
    input  logic            clk,
    input  logic            clr,
    input  logic [47:0]     mac_data,
    input  logic            mac_rdy,
    input  logic [47:0]     mymac,
    input  logic            promisc,
    input  logic            allmulti,
    input  logic            bcast_en,
    input  logic            tbl_we,
    input  logic [IDXW-1:0] tbl_addr,
    input  logic [47:0]     tbl_data,
    input  logic            tbl_clr,
    output logic            cmp_done,
    output logic            cmp_res,
    output logic [2:0]      match_type,
    output logic [IDXW-1:0] match_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_CHECK,
        S_SCAN,
        S_DONE
    } state_t;

    localparam logic [2:0]      MT_NONE  = 3'd0;
    localparam logic [2:0]      MT_OWN   = 3'd1;
    localparam logic [2:0]      MT_BCAST = 3'd2;
    localparam logic [2:0]      MT_MCAST = 3'd3;
    localparam logic [2:0]      MT_TABLE = 3'd4;
    localparam logic [2:0]      MT_PROM  = 3'd5;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NADDR - 1);

    state_t            state_q;
    logic              rdy_prev_q;
    logic [47:0]       addr_q;
    logic              is_bcast_q;
    logic              is_mcast_q;
    logic [IDXW-1:0]   idx_q;
    logic              cmp_done_q;
    logic              cmp_res_q;
    logic [2:0]        match_type_q;
    logic [IDXW-1:0]   match_idx_q;

    logic [NADDR-1:0]  valid_q;
    logic [47:0]       tbl_q [NADDR];

    logic              rise_d;
    logic              tbl_wr_d;
    logic [NADDR-1:0]  hit_vec;
    logic              entry_hit_d;

    assign rise_d   = mac_rdy & ~rdy_prev_q;
    // A clear in the same cycle as a write discards the write.
    assign tbl_wr_d = tbl_we & ~tbl_clr & (32'(tbl_addr) < NADDR);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            valid_q <= '0;
        end else if (tbl_clr) begin
            valid_q <= '0;
        end else if (tbl_wr_d) begin
            valid_q[tbl_addr] <= 1'b1;
        end
    end

    // Address storage carries no reset; the valid bits alone gate a match.
    always_ff @(posedge clk) begin
        if (tbl_wr_d) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    for (genvar gi = 0; gi < NADDR; gi++) begin : g_cmp
        assign hit_vec[gi] = valid_q[gi] && (tbl_q[gi] == addr_q);
    end

    assign entry_hit_d = hit_vec[idx_q];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_IDLE;
            rdy_prev_q   <= 1'b0;
            addr_q       <= '0;
            is_bcast_q   <= 1'b0;
            is_mcast_q   <= 1'b0;
            idx_q        <= '0;
            cmp_done_q   <= 1'b0;
            cmp_res_q    <= 1'b0;
            match_type_q <= MT_NONE;
            match_idx_q  <= '0;
        end else begin
            rdy_prev_q <= mac_rdy;
            case (state_q)
                S_IDLE: begin
                    cmp_done_q   <= 1'b0;
                    cmp_res_q    <= 1'b0;
                    match_type_q <= MT_NONE;
                    match_idx_q  <= '0;
                    if (rise_d) begin
                        addr_q  <= mac_data;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Pre-classify the address so CHECK only has to weigh mode bits.
                    if (!mac_rdy) begin
                        state_q <= S_IDLE;
                    end else begin
                        is_bcast_q <= &addr_q;
                        is_mcast_q <= addr_q[0];
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (!mac_rdy) begin
                        state_q <= S_IDLE;
                    end else if (promisc) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b1;
                        match_type_q <= MT_PROM;
                        state_q      <= S_DONE;
                    end else if (addr_q == mymac) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b1;
                        match_type_q <= MT_OWN;
                        state_q      <= S_DONE;
                    end else if (is_bcast_q && bcast_en) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b1;
                        match_type_q <= MT_BCAST;
                        state_q      <= S_DONE;
                    end else if (is_mcast_q && allmulti && !is_bcast_q) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b1;
                        match_type_q <= MT_MCAST;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q   <= '0;
                        state_q <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (!mac_rdy) begin
                        state_q <= S_IDLE;
                    end else if (entry_hit_d) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b1;
                        match_type_q <= MT_TABLE;
                        match_idx_q  <= idx_q;
                        state_q      <= S_DONE;
                    end else if (idx_q == LAST_IDX) begin
                        cmp_done_q   <= 1'b1;
                        cmp_res_q    <= 1'b0;
                        match_type_q <= MT_NONE;
                        state_q      <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (!mac_rdy) begin
                        cmp_done_q   <= 1'b0;
                        cmp_res_q    <= 1'b0;
                        match_type_q <= MT_NONE;
                        match_idx_q  <= '0;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmp_done   = cmp_done_q;
    assign cmp_res    = cmp_res_q;
    assign match_type = match_type_q;
    assign match_idx  = match_idx_q;

endmodule

// File: tb/tb_ethmacfilt.sv
// Bench for ethmacfilt: a frame-level reference model predicts the result and
// latency of each frame; a per-cycle compare loop checks the outputs against it.
module tb_ethmacfilt;

    localparam int NADDR = 14;
    localparam int IDXW  = 4;
    localparam int BIG   = 32'h3fff_ffff;

    logic            clk = 1'b0;
    logic            clr;
    logic [47:0]     mac_data;
    logic            mac_rdy;
    logic [47:0]     mymac;
    logic            promisc, allmulti, bcast_en;
    logic            tbl_we, tbl_clr;
    logic [IDXW-1:0] tbl_addr;
    logic [47:0]     tbl_data;
    logic            cmp_done, cmp_res;
    logic [2:0]      match_type;
    logic [IDXW-1:0] match_idx;

    ethmacfilt #(.NADDR(NADDR), .IDXW(IDXW)) dut (
        .clk(clk), .clr(clr), .mac_data(mac_data), .mac_rdy(mac_rdy),
        .mymac(mymac), .promisc(promisc), .allmulti(allmulti), .bcast_en(bcast_en),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data), .tbl_clr(tbl_clr),
        .cmp_done(cmp_done), .cmp_res(cmp_res), .match_type(match_type),
        .match_idx(match_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference model: table contents and the prediction for the current frame.
    logic [47:0] m_tab [16];
    bit          m_val [16];
    bit          f_act;
    int          f_rise, f_drop, f_lat;
    bit          f_res;
    logic [2:0]  f_type;
    logic [3:0]  f_idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic predict(input logic [47:0] a);
        f_res = 1'b1;
        f_idx = 4'd0;
        f_lat = 3;
        if (promisc)                                    f_type = 3'd5;
        else if (a == mymac)                            f_type = 3'd1;
        else if (a == 48'hFFFF_FFFF_FFFF && bcast_en)   f_type = 3'd2;
        else if (a[0] && allmulti && a != 48'hFFFF_FFFF_FFFF) f_type = 3'd3;
        else begin
            f_type = 3'd0;
            f_res  = 1'b0;
            f_lat  = NADDR + 3;
            for (int k = NADDR - 1; k >= 0; k--) begin
                if (m_val[k] && m_tab[k] == a) begin
                    f_type = 3'd4;
                    f_res  = 1'b1;
                    f_idx  = 4'(k);
                    f_lat  = k + 4;
                end
            end
        end
    endtask

    task automatic tbl_op(input bit we, input bit clrb, input logic [3:0] a, input logic [47:0] d);
        tbl_we = we; tbl_clr = clrb; tbl_addr = a; tbl_data = d;
        if (clrb) begin
            for (int k = 0; k < 16; k++) m_val[k] = 1'b0;
        end else if (we && int'(a) < NADDR) begin
            m_tab[a] = d;
            m_val[a] = 1'b1;
        end
        tick(1);
        tbl_we = 1'b0; tbl_clr = 1'b0;
    endtask

    task automatic start_frame(input logic [47:0] a);
        mac_data = a;
        mac_rdy  = 1'b1;
        predict(a);
        f_rise = cyc;
        f_drop = BIG;
        f_act  = 1'b1;
    endtask

    task automatic end_frame();
        mac_rdy = 1'b0;
        f_drop  = cyc;
        tick(1);
    endtask

    task automatic frame(input logic [47:0] a, input int hold);
        start_frame(a);
        tick(hold);
        end_frame();
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            begin
                bit win;
                logic [8:0] expv;
                win  = f_act && (cyc >= f_rise + f_lat) && (cyc <= f_drop);
                expv = win ? {1'b1, f_res, f_type, f_idx} : 9'd0;
                checks++;
                if ({cmp_done, cmp_res, match_type, match_idx} !== expv) begin
                    errors++;
                    $display("FAIL cycle_cmp @%0d: got done=%b res=%b type=%0d idx=%0d expected done=%b res=%b type=%0d idx=%0d",
                             cyc, cmp_done, cmp_res, match_type, match_idx,
                             expv[8], expv[7], expv[6:4], expv[3:0]);
                end
            end
        end
    endtask

    logic [47:0] a_tbl, a_col, a_keep, a_b, a_rst;
    logic [63:0] r64;

    initial begin
        clr = 1'b1; mac_data = '0; mac_rdy = 1'b0; mymac = '0;
        promisc = 0; allmulti = 0; bcast_en = 0;
        tbl_we = 0; tbl_clr = 0; tbl_addr = '0; tbl_data = '0;
        f_act = 0; f_rise = 0; f_drop = 0; f_lat = 0; f_res = 0; f_type = 0; f_idx = 0;
        for (int k = 0; k < 16; k++) begin m_tab[k] = '0; m_val[k] = 1'b0; end
        fork
            compare_loop();
        join_none

        tick(3);
        chk("reset_done", cmp_done, 0);
        chk("reset_type", match_type, 0);
        chk("reset_idx", match_idx, 0);
        clr = 1'b0;
        tick(2);

        // Own unicast, hold, then mode changes must not disturb the held result
        mymac = 48'h6655_4433_2211;
        start_frame(48'h6655_4433_2211);
        chk("model_own_type", f_type, 1);
        chk("model_own_lat", f_lat, 3);
        tick(2);
        chk("own_not_yet", cmp_done, 0);
        tick(1);
        chk("own_done_at3", cmp_done, 1);
        chk("own_res", cmp_res, 1);
        chk("own_type", match_type, 1);
        tick(2);
        mymac = 48'h1111_2222_3333; promisc = 1'b1;
        tick(3);
        chk("own_held_type", match_type, 1);
        mymac = 48'h6655_4433_2211; promisc = 1'b0;
        end_frame();
        chk("own_drop_done", cmp_done, 0);
        chk("own_drop_type", match_type, 0);

        // Broadcast, enabled then disabled (empty table)
        bcast_en = 1'b1;
        start_frame(48'hFFFF_FFFF_FFFF);
        chk("model_bc_type", f_type, 2);
        tick(5);
        end_frame();
        bcast_en = 1'b0;
        start_frame(48'hFFFF_FFFF_FFFF);
        chk("model_bcoff_lat", f_lat, 17);
        tick(16);
        chk("bcoff_not_yet", cmp_done, 0);
        tick(1);
        chk("bcoff_done_at17", cmp_done, 1);
        chk("bcoff_res", cmp_res, 0);
        tick(2);
        end_frame();

        // Table hit at entry 5, then miss after table clear
        a_tbl = 48'h0A09_0807_0605;
        tbl_op(1, 0, 4'd5, a_tbl);
        start_frame(a_tbl);
        chk("model_tbl_lat", f_lat, 9);
        chk("model_tbl_idx", f_idx, 5);
        tick(8);
        chk("tbl_not_yet", cmp_done, 0);
        tick(1);
        chk("tbl_done_at9", cmp_done, 1);
        chk("tbl_type", match_type, 4);
        chk("tbl_idx", match_idx, 5);
        tick(2);
        end_frame();
        tbl_op(0, 1, 4'd0, '0);
        start_frame(a_tbl);
        chk("model_tblclr_res", f_res, 0);
        tick(17);
        chk("tblclr_done", cmp_done, 1);
        chk("tblclr_res", cmp_res, 0);
        end_frame();

        // Multicast via allmulti, then promiscuous
        allmulti = 1'b1;
        start_frame(48'h0000_0000_5E01);
        chk("model_mc_type", f_type, 3);
        tick(4);
        chk("mc_type", match_type, 3);
        end_frame();
        allmulti = 1'b0; promisc = 1'b1;
        start_frame(48'h0000_0000_5E01);
        chk("model_prom_type", f_type, 5);
        tick(4);
        chk("prom_type", match_type, 5);
        end_frame();
        promisc = 1'b0;

        // Abort at scan index 3: no completion ever
        frame(48'h0000_0000_5E01, 6);
        for (int i = 0; i < 20; i++) begin
            if (cmp_done !== 1'b0) chk("abort_no_done", cmp_done, 0);
            tick(1);
        end
        chk("abort_idle", cmp_done, 0);

        // Write collision, out-of-range write
        a_col  = 48'h1234_5678_9ABC;
        a_keep = 48'h0C0B_0A09_0807;
        a_b    = 48'h2222_3333_4444;
        tbl_op(1, 0, 4'd2, a_col);
        tbl_op(1, 1, 4'd2, a_col);
        tbl_op(1, 0, 4'd7, a_keep);
        tbl_op(1, 0, 4'd15, a_b);
        start_frame(a_col);
        chk("model_col_type", f_type, 0);
        tick(18);
        chk("col_res", cmp_res, 0);
        end_frame();
        frame(a_b, 18);
        start_frame(a_keep);
        tick(11);
        chk("keep_type", match_type, 4);
        chk("keep_idx", match_idx, 7);
        end_frame();

        // Asynchronous reset while holding a result
        a_rst = 48'h0606_0505_0404;
        tbl_op(1, 0, 4'd3, a_rst);
        start_frame(a_rst);
        tick(8);
        chk("pre_rst_done", cmp_done, 1);
        clr = 1'b1; mac_rdy = 1'b0; f_act = 1'b0;
        for (int k = 0; k < 16; k++) m_val[k] = 1'b0;
        #1;
        chk("async_rst_done", cmp_done, 0);
        chk("async_rst_type", match_type, 0);
        tick(2);
        clr = 1'b0;
        tick(1);
        start_frame(a_rst);
        chk("model_postrst_res", f_res, 0);
        tick(18);
        chk("postrst_res", cmp_res, 0);
        end_frame();

        // Randomized frames against the model
        for (int n = 0; n < 150; n++) begin
            int ops;
            ops = $urandom_range(0, 2);
            for (int j = 0; j < ops; j++) begin
                r64 = {$urandom(), $urandom()};
                if ($urandom_range(0, 3) == 0) r64[47:0] = mymac;
                tbl_op(1'b1, ($urandom_range(0, 15) == 0), 4'($urandom_range(0, 15)), r64[47:0]);
            end
            promisc  = ($urandom_range(0, 9) == 0);
            allmulti = 1'($urandom_range(0, 1));
            bcast_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                r64 = {$urandom(), $urandom()};
                mymac = r64[47:0];
            end
            r64 = {$urandom(), $urandom()};
            case ($urandom_range(0, 4))
                0: r64[47:0] = m_tab[$urandom_range(0, 15)];
                1: r64[47:0] = mymac;
                2: r64[47:0] = 48'hFFFF_FFFF_FFFF;
                3: r64[0] = 1'b1;
                default: ;
            endcase
            frame(r64[47:0], $urandom_range(1, 22));
        end
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
